// File: rtl/complex_div.sv
// Sequential signed complex divider: q = a / b via a*conj(b) / |b|^2, with a
// radix-2 restoring divide running on both quotient parts in parallel.
module complex_div #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 div_zero,
  output logic                 ovf
);

  localparam int unsigned H  = WIDTH / 2;
  localparam int unsigned HW = 2 * H;
  localparam int unsigned QB = 3 * H;
  localparam int unsigned CW = $clog2(QB);

  localparam logic [QB-1:0] POS_LIM = {{(QB-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [QB-1:0] NEG_LIM = {{(QB-WIDTH){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, PREP, DIV, FIN, DONE} state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_q, b_q;
  logic [HW-1:0]    den_q;
  logic [HW-1:0]    rem_r, rem_i;
  logic [QB-1:0]    dq_r, dq_i;
  logic             neg_r, neg_i;
  logic [CW-1:0]    cnt;

  function automatic logic signed [HW-1:0] sx(input logic [H-1:0] v);
    return $signed({{H{v[H-1]}}, v});
  endfunction

  function automatic logic [HW-1:0] mag(input logic signed [HW:0] v);
    return v[HW] ? HW'(-v) : HW'(v);
  endfunction

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  // Remainder stays below den <= 2^(HW-1), so HW bits hold it.
  function automatic logic [HW+QB-1:0] step(input logic [HW-1:0] rem,
                                            input logic [QB-1:0] dq,
                                            input logic [HW-1:0] d);
    logic [HW:0] sh;
    logic        ge;
    sh = {rem, dq[QB-1]};
    ge = (sh >= {1'b0, d});
    return {(ge ? HW'(sh - {1'b0, d}) : HW'(sh)), dq[QB-2:0], ge};
  endfunction

  function automatic logic [WIDTH:0] sat(input logic [QB-1:0] m, input logic neg);
    if (!neg)
      return (m > POS_LIM) ? {2'b10, {(WIDTH-1){1'b1}}} : {1'b0, m[WIDTH-1:0]};
    else
      return (m > NEG_LIM) ? {2'b11, {(WIDTH-1){1'b0}}} : {1'b0, -m[WIDTH-1:0]};
  endfunction

  logic signed [HW-1:0] p_rr, p_ii, p_ir, p_ri, p_bb_r, p_bb_i;
  logic signed [HW:0]   nr, ni;
  logic [HW-1:0]        den_c;
  logic [WIDTH:0]       sat_r, sat_i;

  always_comb begin
    p_rr   = sx(a_q[H-1:0])     * sx(b_q[H-1:0]);
    p_ii   = sx(a_q[WIDTH-1:H]) * sx(b_q[WIDTH-1:H]);
    p_ir   = sx(a_q[WIDTH-1:H]) * sx(b_q[H-1:0]);
    p_ri   = sx(a_q[H-1:0])     * sx(b_q[WIDTH-1:H]);
    p_bb_r = sx(b_q[H-1:0])     * sx(b_q[H-1:0]);
    p_bb_i = sx(b_q[WIDTH-1:H]) * sx(b_q[WIDTH-1:H]);
    nr     = {p_rr[HW-1], p_rr} + {p_ii[HW-1], p_ii};
    ni     = {p_ir[HW-1], p_ir} - {p_ri[HW-1], p_ri};
    den_c  = p_bb_r + p_bb_i;
    sat_r  = sat(dq_r, neg_r);
    sat_i  = sat(dq_i, neg_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid && in_ready) state_next = PREP;
      PREP: state_next = DIV;
      DIV:  if (cnt == '0) state_next = FIN;
      FIN:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      den_q    <= '0;
      rem_r    <= '0;
      rem_i    <= '0;
      dq_r     <= '0;
      dq_i     <= '0;
      neg_r    <= 1'b0;
      neg_i    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      in_ready <= (state_next == IDLE);
      case (state)
        IDLE: if (in_valid && in_ready) begin
          a_q <= dividend;
          b_q <= divisor;
        end
        PREP: begin
          den_q <= den_c;
          neg_r <= nr[HW];
          neg_i <= ni[HW];
          dq_r  <= {mag(nr), {H{1'b0}}};
          dq_i  <= {mag(ni), {H{1'b0}}};
          rem_r <= '0;
          rem_i <= '0;
          cnt   <= CW'(QB - 1);
        end
        DIV: begin
          {rem_r, dq_r} <= step(rem_r, dq_r, den_q);
          {rem_i, dq_i} <= step(rem_i, dq_i, den_q);
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        FIN: begin
          // den == 0: iterations ran regardless; their output is discarded here.
          if (den_q == '0) begin
            result   <= '0;
            div_zero <= 1'b1;
            ovf      <= 1'b0;
          end else begin
            result   <= {sat_r[WIDTH-1:0], sat_i[WIDTH-1:0]};
            div_zero <= 1'b0;
            ovf      <= sat_r[WIDTH] | sat_i[WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_complex_div.sv
// Directed bench for complex_div (WIDTH = 32) with hand-computed quotients.
module tb_complex_div;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        div_zero;
  logic        ovf;

  int checks = 0;
  int errors = 0;

  complex_div #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .div_zero  (div_zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int re, input int im);
    logic [31:0] r;
    logic [31:0] i;
    r = re;
    i = im;
    return {i[15:0], r[15:0]};
  endfunction

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp_res, input logic exp_dz, input logic exp_ovf,
                     input logic release_now);
    int lat;
    @(negedge clk);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'd50);
    chk({tag, ".result"}, result, exp_res);
    chk({tag, ".div_zero"}, 64'(div_zero), 64'(exp_dz));
    chk({tag, ".ovf"}, 64'(ovf), 64'(exp_ovf));
    if (release_now) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, ".out_valid_clr"}, 64'(out_valid), 64'd0);
      chk({tag, ".in_ready_back"}, 64'(in_ready), 64'd1);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.result", result, 64'd0);
    chk("rst.flags", {62'd0, div_zero, ovf}, 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.in_ready_after", 64'(in_ready), 64'd1);

    run("real_4_2", pk(4, 0), pk(2, 0), 64'h00020000_00000000, 1'b0, 1'b0, 1'b1);
    run("cplx_1p1j_j", pk(1, 1), pk(0, 1), 64'h00010000_FFFF0000, 1'b0, 1'b0, 1'b1);
    run("cplx_3p4j_1p2j", pk(3, 4), pk(1, 2), 64'h00023333_FFFF999A, 1'b0, 1'b0, 1'b1);
    run("div_zero", pk(5, 7), pk(0, 0), 64'h0, 1'b1, 1'b0, 1'b1);
    run("sat_pos", pk(-32768, -32768), pk(-1, -1), 64'h7FFFFFFF_00000000, 1'b0, 1'b1, 1'b1);

    // Backpressure: hold the result for 20 cycles while poking in_valid.
    run("bp", pk(32767, 0), pk(1, 0), 64'h7FFF0000_00000000, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = pk(i + 1, 3);
      divisor  = pk(1, 1);
      @(posedge clk);
      #1;
      chk("bp.result_hold", result, 64'h7FFF0000_00000000);
      chk("bp.flags_hold", {61'd0, out_valid, div_zero, ovf}, 64'd4);
      chk("bp.in_ready_low", 64'(in_ready), 64'd0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp.in_ready_next", 64'(in_ready), 64'd1);
    chk("bp.out_valid_clr", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("bp.no_ghost_op", 64'(out_valid), 64'd0);
    chk("bp.idle_ready", 64'(in_ready), 64'd1);

    // Reset during the divide loop, then a fresh operation.
    @(negedge clk);
    dividend = pk(3, 4);
    divisor  = pk(1, 2);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.result", result, 64'd0);
    chk("midrst.flags", {62'd0, div_zero, ovf}, 64'd0);
    chk("midrst.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst.in_ready_after", 64'(in_ready), 64'd1);
    chk("midrst.no_stale", 64'(out_valid), 64'd0);

    run("post_rst_4_2", pk(4, 0), pk(2, 0), 64'h00020000_00000000, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
